// File: rtl/softmax_normalize_seq_pkg.sv
// Shared defaults and FSM state encoding for the softmax normaliser.
package softmax_normalize_seq_pkg;

    localparam int unsigned NUM_CLASSES_DEF = 10;
    localparam int unsigned IN_W_DEF        = 16;
    localparam int unsigned FRAC_W_DEF      = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/softmax_normalize_seq_div.sv
// Restoring divider producing Q_W quotient bits, one per cycle, for dividend <= divisor.
// Bit 0 of the iteration sequence is the integer bit; later bits shift the remainder first.
module seq_restoring_divider #(
    parameter int unsigned DVD_W = 17,
    parameter int unsigned Q_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVD_W-1:0] divisor,
    output logic             busy,
    output logic             done_c,
    output logic [Q_W-1:0]   quotient_c
);

    localparam int unsigned REM_W = DVD_W + 1;
    localparam int unsigned CNT_W = $clog2(Q_W);

    logic [REM_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [REM_W-1:0] trial;

    // Load on start, then one restoring step per cycle until Q_W bits are produced.
    always_comb begin
        rem_d  = rem_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = '0;
        done_c = 1'b0;
        if (busy_q) begin
            trial = (cnt_q == '0) ? rem_q : {rem_q[REM_W-2:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                rem_d = trial - {1'b0, divisor};
                q_d   = {q_q[Q_W-2:0], 1'b1};
            end else begin
                rem_d = trial;
                q_d   = {q_q[Q_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(Q_W - 1)) begin
                busy_d = 1'b0;
                done_c = 1'b1;
            end
        end else if (start) begin
            rem_d  = REM_W'(dividend);
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign quotient_c = q_d;

endmodule

// File: rtl/softmax_normalize_seq.sv
// Sequential softmax normaliser: capture vector, accumulate sum, divide each element by the sum.
module softmax_normalize_seq
    import softmax_normalize_seq_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned IN_W        = IN_W_DEF,
    parameter int unsigned FRAC_W      = FRAC_W_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CLASSES*IN_W-1:0]       in_vector,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CLASSES*(FRAC_W+1)-1:0] out_vector,
    output logic                              zero_sum,
    output logic                              busy
);

    localparam int unsigned OUT_W = FRAC_W + 1;
    localparam int unsigned SUM_W = IN_W + $clog2(NUM_CLASSES);
    localparam int unsigned IDX_W = $clog2(NUM_CLASSES);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  x_q   [NUM_CLASSES];
    logic [IN_W-1:0]  x_d   [NUM_CLASSES];
    logic [OUT_W-1:0] res_q [NUM_CLASSES];
    logic [OUT_W-1:0] res_d [NUM_CLASSES];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_sum_q, zero_sum_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [SUM_W-1:0] sum_acc_c;
    logic             last_idx_c;
    logic             div_start_c;
    logic             div_busy;
    logic             div_done_c;
    logic [OUT_W-1:0] div_quot_c;

    assign sum_acc_c  = sum_q + SUM_W'(x_q[idx_q]);
    assign last_idx_c = (idx_q == IDX_W'(NUM_CLASSES - 1));

    seq_restoring_divider #(
        .DVD_W (SUM_W),
        .Q_W   (OUT_W)
    ) u_div (
        .clock      (clock),
        .reset      (reset),
        .start      (div_start_c),
        .dividend   (SUM_W'(x_q[idx_q])),
        .divisor    (sum_q),
        .busy       (div_busy),
        .done_c     (div_done_c),
        .quotient_c (div_quot_c)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero sum skips the divide phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid && in_ready_q) state_d = ST_SUM;
            ST_SUM:  if (last_idx_c) state_d = (sum_acc_c == '0) ? ST_OUT : ST_DIV;
            ST_DIV:  if (div_done_c && last_idx_c) state_d = ST_OUT;
            ST_OUT:  if (out_valid_q && out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; out_valid rises one cycle after entering OUT.
    always_comb begin
        x_d         = x_q;
        res_d       = res_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        zero_sum_d  = zero_sum_q;
        out_valid_d = out_valid_q;
        div_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        x_d[k] = in_vector[k*IN_W +: IN_W];
                    end
                    sum_d = '0;
                    idx_d = '0;
                end
            end
            ST_SUM: begin
                sum_d = sum_acc_c;
                if (last_idx_c) begin
                    idx_d = '0;
                    if (sum_acc_c == '0) begin
                        zero_sum_d = 1'b1;
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            res_d[k] = '0;
                        end
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DIV: begin
                div_start_c = !div_busy;
                if (div_done_c) begin
                    res_d[idx_q] = div_quot_c;
                    if (last_idx_c) begin
                        zero_sum_d = 1'b0;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // Datapath and output registers; reset discards any in-flight vector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                x_q[k]   <= '0;
                res_q[k] <= '0;
            end
            sum_q       <= '0;
            idx_q       <= '0;
            zero_sum_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            x_q         <= x_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            zero_sum_q  <= zero_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_out
        assign out_vector[g*OUT_W +: OUT_W] = res_q[g];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign zero_sum  = zero_sum_q;
    assign busy      = busy_q;

endmodule
